// File: rtl/change_event_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : change_event_fifo_if
// Brief    : Show-ahead valid/ready event stream (word plus capture timestamp).
// Revision : 1.0 - initial release
// ============================================================================
interface change_event_fifo_if #(
    parameter int TS_W = 16
);
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_data;
    logic [TS_W-1:0] out_ts;

    modport master (output out_valid, output out_data, output out_ts, input out_ready);
    modport slave  (input out_valid, input out_data, input out_ts, output out_ready);
endinterface
`default_nettype wire

// File: rtl/change_event_fifo.sv
`default_nettype none
// ============================================================================
// Module   : change_event_fifo
// Brief    : Timestamps every non-zero change word and queues it in a show-ahead
//            FIFO; overflow losses go to a saturating drop counter.
// Revision : 1.0 - initial release
// ============================================================================
module change_event_fifo #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic [7:0]               evt_in,
    change_event_fifo_if.master           evq,
    output logic [$clog2(DEPTH):0]        level,
    output logic                          full,
    output logic                          empty,
    output logic [7:0]                    drop_cnt,
    input  wire logic                     clr_drop
);
    localparam int                c_AW       = $clog2(DEPTH);
    localparam int                c_LW       = c_AW + 1;
    localparam logic [c_LW-1:0]   c_FULL_LVL = c_LW'(DEPTH);
    localparam logic [7:0]        c_DROP_MAX = 8'hFF;

    logic [7:0]      r_mem_data [DEPTH];
    logic [TS_W-1:0] r_mem_ts   [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_LW-1:0] r_level;
    logic [TS_W-1:0] r_ts;
    logic [7:0]      r_drop_cnt;

    logic w_push;
    logic w_pop;
    logic w_wr_en;
    logic w_drop;
    logic w_full;
    logic w_empty;

    assign w_full  = (r_level == c_FULL_LVL);
    assign w_empty = (r_level == '0);
    assign w_push  = (evt_in != 8'h00);
    assign w_pop   = !w_empty && evq.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts       <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (clr_drop) begin
                r_drop_cnt <= w_drop ? 8'd1 : 8'd0;
            end else if (w_drop && (r_drop_cnt != c_DROP_MAX)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    // Storage is deliberately left unreset; level gates visibility of stale data.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_data[r_wr_ptr] <= evt_in;
            r_mem_ts[r_wr_ptr]   <= r_ts;
        end
    end

    assign evq.out_valid = !w_empty;
    assign evq.out_data  = w_empty ? 8'h00 : r_mem_data[r_rd_ptr];
    assign evq.out_ts    = w_empty ? '0    : r_mem_ts[r_rd_ptr];
    assign level         = r_level;
    assign full          = w_full;
    assign empty         = w_empty;
    assign drop_cnt      = r_drop_cnt;
endmodule
`default_nettype wire
